calc_disp_ctrl: RTL and testbench

Sequencing controller for the calculator datapath: owns the operand/operation registers driving the 8-bit adder/subtractor, samples its signed 9-bit result once per display frame, converts the magnitude to BCD with a sequential double-dabble engine, and time-multiplexes the four 7-segment digits. It also debounces KEY0 and applies leading-zero and sign blanking. It replaces the free-running divider, anode selector and combinational BCD converter in the top level. The existing BCD-to-segment decoder stays downstream.

---
 rtl/calc_ctrl_pkg.sv | 24 ++
 rtl/bin2bcd_seq.sv | 45 ++++
 rtl/calc_disp_ctrl.sv | 179 +++++++++++++++++
 tb/tb_calc_disp_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_ctrl_pkg.sv
// Shared types and constants for the calculator display controller.
// Holds the capture FSM states, digit slot indices and the double-dabble helpers.
package calc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    CONV   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic [1:0] DIG_UNITS    = 2'd0;
  localparam logic [1:0] DIG_TENS     = 2'd1;
  localparam logic [1:0] DIG_HUNDREDS = 2'd2;
  localparam logic [1:0] DIG_SIGN     = 2'd3;

  localparam int BCD_ITERS = 9;

  // Double-dabble correction applied to one BCD nibble before each shift.
  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: converts a 9-bit magnitude to three BCD nibbles,
// one shift per cycle. o_done pulses during the cycle of the final iteration.
module bin2bcd_seq
  import calc_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [8:0]  i_bin,
  output logic [11:0] o_bcd,
  output logic        o_done
);

  logic [8:0]  r_bin;
  logic [11:0] r_bcd;
  logic [3:0]  r_cnt;
  logic        r_run;
  logic [11:0] w_adj;
  logic        w_last;

  assign w_adj  = {dd_adj(r_bcd[11:8]), dd_adj(r_bcd[7:4]), dd_adj(r_bcd[3:0])};
  assign w_last = (r_cnt == 4'(BCD_ITERS - 1));
  assign o_done = r_run && w_last;
  assign o_bcd  = r_bcd;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_bin <= i_bin;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_bcd <= {w_adj[10:0], r_bin[8]};
      r_bin <= {r_bin[7:0], 1'b0};
      r_cnt <= r_cnt + 4'd1;
      if (w_last) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_disp_ctrl.sv
// Calculator sequencing/display controller: operand capture, BCD conversion and
// 4-digit scan. Define LZ_BLANK_EN to blank leading zeros in hundreds/tens.
module calc_disp_ctrl
  import calc_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV = 12500,
  parameter int DEB_CYCLES  = 500000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] SW_A,
  input  logic [7:0] SW_B,
  input  logic       KEY0,
  input  logic [8:0] RES,
  output logic [7:0] OP_A,
  output logic [7:0] OP_B,
  output logic       OP_SUB,
  output logic [3:0] AN,
  output logic [1:0] SEL,
  output logic [3:0] DIGIT,
  output logic       BLANK,
  output logic       MINUS,
  output logic       BUSY,
  output logic [1:0] DBG_STATE
);

  localparam int SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);

  logic              r_key_s1, r_key_s2, r_key_deb;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [SCAN_W-1:0] r_scan;
  logic [1:0]        r_sel;
  state_t            r_state, w_state_nxt;
  logic              r_sign, r_buf_sign;
  logic [11:0]       r_buf_bcd;
  logic              w_tc, w_tick, w_load_ops, w_start, w_commit, w_done;
  logic [8:0]        w_mag;
  logic [11:0]       w_bcd;

  // Key: two-flop synchronizer, then a level that flips only after a run of
  // DEB_CYCLES consecutive samples disagreeing with it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_key_s1  <= 1'b1;
      r_key_s2  <= 1'b1;
      r_key_deb <= 1'b1;
      r_deb_cnt <= '0;
    end else begin
      r_key_s1 <= KEY0;
      r_key_s2 <= r_key_s1;
      if (r_key_s2 == r_key_deb) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        r_key_deb <= r_key_s2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  assign w_tc   = (r_scan == SCAN_W'(REFRESH_DIV - 1));
  assign w_tick = w_tc && (r_sel == DIG_SIGN);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_scan <= '0;
      r_sel  <= DIG_UNITS;
    end else if (w_tc) begin
      r_scan <= '0;
      r_sel  <= r_sel + 2'd1;
    end else begin
      r_scan <= r_scan + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_ops  = 1'b0;
    w_start     = 1'b0;
    w_commit    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_load_ops  = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        w_start     = 1'b1;
        w_state_nxt = CONV;
      end
      CONV: begin
        if (w_done) w_state_nxt = COMMIT;
      end
      COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Magnitude of the signed adder result; -256 maps to 256, which 9 bits hold.
  assign w_mag = RES[8] ? (~RES + 9'd1) : RES;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OP_A       <= '0;
      OP_B       <= '0;
      OP_SUB     <= 1'b0;
      r_sign     <= 1'b0;
      r_buf_sign <= 1'b0;
      r_buf_bcd  <= '0;
    end else begin
      if (w_load_ops) begin
        OP_A   <= SW_A;
        OP_B   <= SW_B;
        OP_SUB <= ~r_key_deb;
      end
      if (w_start) r_sign <= RES[8];
      if (w_commit) begin
        r_buf_sign <= r_sign;
        r_buf_bcd  <= w_bcd;
      end
    end
  end

  bin2bcd_seq u_bin2bcd (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_start (w_start),
    .i_bin   (w_mag),
    .o_bcd   (w_bcd),
    .o_done  (w_done)
  );

  assign SEL       = r_sel;
  assign AN        = ~(4'b0001 << r_sel);
  assign BUSY      = (r_state != IDLE);
  assign DBG_STATE = r_state;

  always_comb begin
    DIGIT = 4'd0;
    BLANK = 1'b0;
    MINUS = 1'b0;
    unique case (r_sel)
      DIG_SIGN: begin
        MINUS = r_buf_sign;
        BLANK = ~r_buf_sign;
      end
      DIG_HUNDREDS: begin
        DIGIT = r_buf_bcd[11:8];
`ifdef LZ_BLANK_EN
        BLANK = (r_buf_bcd[11:8] == 4'd0);
`else
        BLANK = 1'b0;
`endif
      end
      DIG_TENS: begin
        DIGIT = r_buf_bcd[7:4];
`ifdef LZ_BLANK_EN
        BLANK = (r_buf_bcd[11:4] == 8'd0);
`else
        BLANK = 1'b0;
`endif
      end
      default: begin
        DIGIT = r_buf_bcd[3:0];
      end
    endcase
  end

endmodule

// File: tb/tb_calc_disp_ctrl.sv
// Self-checking bench for calc_disp_ctrl with a behavioural adder and a
// decimal reference model of the display; scan/debounce shrunk to 16/8 cycles.
module tb_calc_disp_ctrl;

  localparam int RDIV = 16;
  localparam int DEB  = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] SW_A = 8'd0;
  logic [7:0] SW_B = 8'd0;
  logic       KEY0 = 1'b1;
  logic [8:0] RES;
  logic [7:0] OP_A, OP_B;
  logic       OP_SUB, BLANK, MINUS, BUSY;
  logic [3:0] AN, DIGIT;
  logic [1:0] SEL, DBG_STATE;

  int errors = 0;
  int checks = 0;
  int prev_units = 0;
  logic [12:0] exp_q[$];

  calc_disp_ctrl #(.REFRESH_DIV(RDIV), .DEB_CYCLES(DEB)) dut (
    .CLK(CLK), .RST(RST), .SW_A(SW_A), .SW_B(SW_B), .KEY0(KEY0), .RES(RES),
    .OP_A(OP_A), .OP_B(OP_B), .OP_SUB(OP_SUB), .AN(AN), .SEL(SEL),
    .DIGIT(DIGIT), .BLANK(BLANK), .MINUS(MINUS), .BUSY(BUSY),
    .DBG_STATE(DBG_STATE)
  );

  // Clock and watchdog
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  // External 8-bit adder/subtractor the controller drives.
  assign RES = OP_SUB ? ({1'b0, OP_A} - {1'b0, OP_B}) : ({1'b0, OP_A} + {1'b0, OP_B});

  function automatic logic exp_blank(input int slot, input int h, input int t, input logic sign);
    if (slot == 3) return !sign;
`ifdef LZ_BLANK_EN
    if (slot == 2) return (h == 0);
    if (slot == 1) return (h == 0 && t == 0);
`endif
    return 1'b0;
  endfunction

  task automatic test_reset();
    int es;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (AN !== 4'b1110) begin errors++; $display("FAIL reset_an got %b exp 1110", AN); end
    checks++; if (SEL !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", SEL); end
    checks++; if (DIGIT !== 4'd0) begin errors++; $display("FAIL reset_digit got %0d exp 0", DIGIT); end
    checks++; if (BLANK !== 1'b0) begin errors++; $display("FAIL reset_blank got %b exp 0", BLANK); end
    checks++; if (MINUS !== 1'b0) begin errors++; $display("FAIL reset_minus got %b exp 0", MINUS); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    checks++; if ({OP_A, OP_B, OP_SUB} !== 17'd0) begin errors++; $display("FAIL reset_ops got %h/%h/%b exp 0", OP_A, OP_B, OP_SUB); end
    RST = 1'b0;
    for (int k = 0; k <= 70; k++) begin
      if (k > 0) @(negedge CLK);
      es = (k / RDIV) % 4;
      checks++;
      if (SEL !== 2'(es) || AN !== ~(4'b0001 << es)) begin
        errors++; $display("FAIL scan_k%0d got sel=%0d an=%b exp sel=%0d", k, SEL, AN, es);
      end
    end
    prev_units = 0;
  endtask

  task automatic wait_level(input logic lvl, input string tag);
    int n = 0;
    while (BUSY !== lvl && n < 200) begin @(negedge CLK); n++; end
    checks++;
    if (BUSY !== lvl) begin errors++; $display("FAIL %s_wait_busy got %b exp %b", tag, BUSY, lvl); end
  endtask

  // One capture frame: apply inputs in the quiet window after a commit, then
  // check operand load, busy length, commit instant and all four slots.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic key,
                           input logic glitch, input logic no_sync, input string tag);
    int val, mag, h, t, u, n, slot;
    logic sign;
    logic [3:0] last_digit;
    logic [12:0] e;
    if (!no_sync) begin
      wait_level(1'b1, tag);
      wait_level(1'b0, tag);
    end
    SW_A = a; SW_B = b; KEY0 = key;
    if (glitch) begin
      repeat (15) @(negedge CLK);
      KEY0 = 1'b0;
      repeat (5) @(negedge CLK);
      KEY0 = 1'b1;
    end
    val  = key ? (int'(a) + int'(b)) : (int'(a) - int'(b));
    sign = (val < 0);
    mag  = sign ? -val : val;
    exp_q.push_back({sign, 4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)});

    wait_level(1'b1, tag);
    checks++;
    if (OP_A !== a || OP_B !== b || OP_SUB !== ~key) begin
      errors++; $display("FAIL %s_ops got %0d/%0d/%b exp %0d/%0d/%b", tag, OP_A, OP_B, OP_SUB, a, b, ~key);
    end
    n = 0;
    last_digit = 4'd0;
    while (BUSY === 1'b1 && n < 40) begin
      n++;
      last_digit = DIGIT;
      @(negedge CLK);
    end
    checks++;
    if (n != 11) begin errors++; $display("FAIL %s_busy_len got %0d exp 11", tag, n); end
    checks++;
    if (last_digit !== 4'(prev_units)) begin
      errors++; $display("FAIL %s_pre_commit got %0d exp %0d", tag, last_digit, prev_units);
    end

    e = exp_q.pop_front();
    h = int'(e[11:8]); t = int'(e[7:4]); u = int'(e[3:0]);
    checks++;
    if (SEL !== 2'd0 || DIGIT !== e[3:0] || BLANK !== 1'b0 || MINUS !== 1'b0) begin
      errors++; $display("FAIL %s_units got sel=%0d d=%0d b=%b m=%b exp sel=0 d=%0d b=0 m=0", tag, SEL, DIGIT, BLANK, MINUS, u);
    end
    for (slot = 1; slot <= 3; slot++) begin
      n = 0;
      while (SEL !== 2'(slot) && n < 40) begin @(negedge CLK); n++; end
      checks++;
      if (SEL !== 2'(slot) || AN !== ~(4'b0001 << slot)
          || DIGIT !== ((slot == 1) ? e[7:4] : (slot == 2) ? e[11:8] : 4'd0)
          || BLANK !== exp_blank(slot, h, t, e[12])
          || MINUS !== ((slot == 3) ? e[12] : 1'b0)) begin
        errors++;
        $display("FAIL %s_slot%0d got sel=%0d an=%b d=%0d b=%b m=%b exp h=%0d t=%0d sign=%b", tag, slot, SEL, AN, DIGIT, BLANK, MINUS, h, t, e[12]);
      end
    end
    prev_units = u;
  endtask

  task automatic test_add();
    run_frame(8'd200, 8'd55, 1'b1, 1'b0, 1'b0, "add");
  endtask

  task automatic test_glitch();
    run_frame(8'd200, 8'd55, 1'b1, 1'b1, 1'b0, "glitch");
  endtask

  task automatic test_sub();
    run_frame(8'd5, 8'd130, 1'b0, 1'b0, 1'b0, "sub");
  endtask

  task automatic test_lz();
    run_frame(8'd7, 8'd0, 1'b1, 1'b0, 1'b0, "lz");
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic key;
    for (int i = 0; i < 6; i++) begin
      a   = 8'($urandom_range(0, 255));
      key = 1'($urandom_range(0, 1));
      b   = key ? 8'($urandom_range(0, 255 - int'(a))) : 8'($urandom_range(0, 255));
      run_frame(a, b, key, 1'b0, 1'b0, $sformatf("rnd%0d", i));
    end
  endtask

  task automatic test_reset_mid();
    run_frame(8'd99, 8'd250, 1'b0, 1'b0, 1'b0, "pre_rst");
    wait_level(1'b1, "rst_mid");
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    #1;
    checks++;
    if (BUSY !== 1'b0 || DIGIT !== 4'd0 || MINUS !== 1'b0 || SEL !== 2'd0 || OP_A !== 8'd0) begin
      errors++; $display("FAIL rst_mid got busy=%b d=%0d m=%b sel=%0d opa=%0d exp all 0", BUSY, DIGIT, MINUS, SEL, OP_A);
    end
    @(negedge CLK);
    RST = 1'b0;
    prev_units = 0;
    run_frame(8'd99, 8'd250, 1'b0, 1'b0, 1'b1, "post_rst");
  endtask

  initial begin
    test_reset();
    test_add();
    test_glitch();
    test_sub();
    test_lz();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
